// File: rtl/tx_engine_pkg.sv
// Shared types and helpers for the transmit engine.
// Holds source indices, the arbiter state encoding and the round-robin pick function.
package tx_engine_pkg;

  localparam int TX_DIR_CPU  = 0;
  localparam int TX_DIR_GEN  = 1;
  localparam int TX_DIR_LOOP = 2;
  localparam int TX_DIR_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } tx_arb_state_t;

  // One-hot pick of the first requester strictly after 'last', wrapping modulo n.
  function automatic logic [TX_DIR_MAX-1:0] rr_pick(
    input logic [TX_DIR_MAX-1:0] req,
    input logic [2:0]            last,
    input int                    n
  );
    logic [TX_DIR_MAX-1:0] onehot;
    logic                  found;
    logic [2:0]            idx;
    int                    s;
    onehot = '0;
    found  = 1'b0;
    for (int i = 1; i <= TX_DIR_MAX; i++) begin
      if (i <= n) begin
        s = int'(last) + i;
        if (s >= n) s = s - n;
        idx = 3'(s);
        if (!found && req[idx]) begin
          onehot[idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/tx_rr_sel.sv
// Combinational round-robin picker: request vector plus last grant -> next grant index.
// Only meaningful when any_o is high; idx_o is 0 otherwise.
module tx_rr_sel
  import tx_engine_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [TX_DIR_MAX-1:0] req_ext;
  logic [TX_DIR_MAX-1:0] onehot;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req_i;
    onehot         = rr_pick(req_ext, 3'(last_i), N);
    idx_o          = '0;
    for (int k = 0; k < TX_DIR_MAX; k++) begin
      if (onehot[k] && (k < N)) idx_o = IDX_W'(k);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/tx_pkt_arb.sv
// Packet-granular round-robin arbiter merging several TX source streams into one,
// with a programmable inter-packet idle gap, per-source packet counters and a sticky error flag.
module tx_pkt_arb
  import tx_engine_pkg::*;
#(
  parameter int TX_DIR_CNT = 2,
  parameter int DATA_W     = 64,
  parameter int EMPTY_W    = 3,
  parameter int CNT_W      = 32,
  parameter int GAP_W      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [TX_DIR_CNT*DATA_W-1:0]  src_data_i,
  input  logic [TX_DIR_CNT*EMPTY_W-1:0] src_empty_i,
  input  logic [TX_DIR_CNT-1:0]         src_sop_i,
  input  logic [TX_DIR_CNT-1:0]         src_eop_i,
  input  logic [TX_DIR_CNT-1:0]         src_val_i,
  output logic [TX_DIR_CNT-1:0]         src_ready_o,
  output logic [DATA_W-1:0]             tx_data_o,
  output logic [EMPTY_W-1:0]            tx_empty_o,
  output logic                          tx_sop_o,
  output logic                          tx_eop_o,
  output logic                          tx_val_o,
  input  logic                          tx_ready_i,
  input  logic [GAP_W-1:0]              gap_len_i,
  input  logic [TX_DIR_CNT-1:0]         src_en_i,
  input  logic                          cnt_clr_i,
  output logic [TX_DIR_CNT*CNT_W-1:0]   pkt_cnt_o,
  output logic                          proto_err_o
);

  localparam int              IDX_W    = (TX_DIR_CNT > 1) ? $clog2(TX_DIR_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(TX_DIR_CNT - 1);

  tx_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q [TX_DIR_CNT];
  logic [CNT_W-1:0] cnt_d [TX_DIR_CNT];

  logic [TX_DIR_CNT-1:0] req;
  logic [TX_DIR_CNT-1:0] garbage;
  logic [IDX_W-1:0]      pick_idx;
  logic                  any_req;

  logic [DATA_W-1:0]  g_data;
  logic [EMPTY_W-1:0] g_empty;
  logic               g_sop;
  logic               g_eop;
  logic               g_val;

  assign req     = src_val_i & src_sop_i & src_en_i;
  // Non-sop words seen while idle belong to no packet and are drained as errors.
  assign garbage = src_val_i & ~src_sop_i;

  tx_rr_sel #(
    .N     (TX_DIR_CNT),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req_i  (req),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (any_req)
  );

  always_comb begin
    g_data  = '0;
    g_empty = '0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_val   = 1'b0;
    for (int k = 0; k < TX_DIR_CNT; k++) begin
      if (grant_q == IDX_W'(k)) begin
        g_data  = src_data_i[k*DATA_W +: DATA_W];
        g_empty = src_empty_i[k*EMPTY_W +: EMPTY_W];
        g_sop   = src_sop_i[k];
        g_eop   = src_eop_i[k];
        g_val   = src_val_i[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    gap_d       = gap_q;
    first_d     = first_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    src_ready_o = '0;
    tx_data_o   = '0;
    tx_empty_o  = '0;
    tx_sop_o    = 1'b0;
    tx_eop_o    = 1'b0;
    tx_val_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        src_ready_o = garbage;
        if (|garbage) err_d = 1'b1;
        if (any_req) begin
          grant_d = pick_idx;
          first_d = 1'b1;
          state_d = XFER;
        end
      end

      XFER: begin
        tx_data_o  = g_data;
        tx_empty_o = g_empty;
        tx_sop_o   = g_sop;
        tx_eop_o   = g_eop;
        tx_val_o   = g_val;
        for (int k = 0; k < TX_DIR_CNT; k++) begin
          if (grant_q == IDX_W'(k)) src_ready_o[k] = tx_ready_i;
        end
        if (g_val && tx_ready_i) begin
          first_d = 1'b0;
          if (g_sop && !first_q) err_d = 1'b1;
          if (g_eop) begin
            for (int k = 0; k < TX_DIR_CNT; k++) begin
              if (grant_q == IDX_W'(k)) cnt_d[k] = cnt_q[k] + 1'b1;
            end
            last_d = grant_q;
            if (gap_len_i == '0) begin
              state_d = IDLE;
            end else begin
              gap_d   = gap_len_i;
              state_d = GAP;
            end
          end
        end
      end

      GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
        else                    gap_d   = gap_q - 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // Clear takes priority over a same-cycle increment or error.
    if (cnt_clr_i) begin
      for (int k = 0; k < TX_DIR_CNT; k++) cnt_d[k] = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      gap_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < TX_DIR_CNT; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      first_q <= first_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < TX_DIR_CNT; k++) pkt_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign proto_err_o = err_q;

endmodule

// File: tb/tb_tx_pkt_arb.sv
// Bench for tx_pkt_arb: per-source word queues feed the DUT, a packet-level round-robin
// scoreboard checks every output cycle, and directed steps pin literal expectations.
module tb_tx_pkt_arb;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 4;
  localparam int GW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
    logic          garbage;
  } word_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] src_data = '0;
  logic [N*EW-1:0] src_empty = '0;
  logic [N-1:0]    src_sop = '0;
  logic [N-1:0]    src_eop = '0;
  logic [N-1:0]    src_val = '0;
  logic [N-1:0]    src_en = '1;
  logic [N-1:0]    src_ready;
  logic [DW-1:0]   tx_data;
  logic [EW-1:0]   tx_empty;
  logic            tx_sop, tx_eop, tx_val;
  logic            tx_ready = 1'b1;
  logic [GW-1:0]   gap_len = '0;
  logic            cnt_clr = 1'b0;
  logic [N*CW-1:0] pkt_cnt;
  logic            proto_err;

  always #5 clk = ~clk;

  tx_pkt_arb #(
    .TX_DIR_CNT (N), .DATA_W (DW), .EMPTY_W (EW), .CNT_W (CW), .GAP_W (GW)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .src_data_i  (src_data),
    .src_empty_i (src_empty),
    .src_sop_i   (src_sop),
    .src_eop_i   (src_eop),
    .src_val_i   (src_val),
    .src_ready_o (src_ready),
    .tx_data_o   (tx_data),
    .tx_empty_o  (tx_empty),
    .tx_sop_o    (tx_sop),
    .tx_eop_o    (tx_eop),
    .tx_val_o    (tx_val),
    .tx_ready_i  (tx_ready),
    .gap_len_i   (gap_len),
    .src_en_i    (src_en),
    .cnt_clr_i   (cnt_clr),
    .pkt_cnt_o   (pkt_cnt),
    .proto_err_o (proto_err)
  );

  word_t       srcq [N][$];
  word_t       expq [N][$];
  logic [N-1:0] hs = '0;
  int          cur_src = -1;
  int          model_last = N - 1;
  logic [CW-1:0] exp_cnt [N];
  logic        exp_err = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cycle_no = 0;
  bit          gap_chk = 1'b0;
  bit          eop_seen = 1'b0;
  int          last_eop_cyc = 0;
  logic [7:0]  sop_order [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      srcq[k].delete();
      expq[k].delete();
      exp_cnt[k] = '0;
    end
    cur_src    = -1;
    model_last = N - 1;
    exp_err    = 1'b0;
    eop_seen   = 1'b0;
  endtask

  task automatic push_pkt(input int src, input int nw, input int tag);
    word_t w;
    for (int i = 0; i < nw; i++) begin
      w.data    = {8'(src), 8'(tag), 40'h5A_C3_96_0F_E1, 8'(i)};
      w.empty   = 3'(i + tag);
      w.sop     = (i == 0);
      w.eop     = (i == nw - 1);
      w.garbage = 1'b0;
      srcq[src].push_back(w);
      expq[src].push_back(w);
    end
  endtask

  task automatic wait_idle(input int skip);
    int t = 0;
    int pend;
    pend = 1;
    while (pend != 0 && t < 400) begin
      pend = (cur_src >= 0) ? 1 : 0;
      for (int k = 0; k < N; k++) if (k != skip && expq[k].size() > 0) pend = 1;
      if (pend != 0) begin
        @(negedge clk);
        t++;
      end
    end
    if (t >= 400) chk("drain_timeout", 64'(t), 64'(0));
    @(posedge clk); #1;
  endtask

  // Source drivers: retire the word handshaken at the last edge, present the next one.
  initial forever begin
    @(posedge clk); #2;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && srcq[k].size() > 0) srcq[k].delete(0);
      if (srcq[k].size() > 0) begin
        src_val[k]             = 1'b1;
        src_sop[k]             = srcq[k][0].sop;
        src_eop[k]             = srcq[k][0].eop;
        src_data[k*DW +: DW]   = srcq[k][0].data;
        src_empty[k*EW +: EW]  = srcq[k][0].empty;
      end else begin
        src_val[k] = 1'b0;
        src_sop[k] = 1'b0;
        src_eop[k] = 1'b0;
      end
    end
  end

  // Scoreboard: packets leave whole, in round-robin order among sources with pending packets.
  initial forever begin
    word_t w;
    int    pick;
    @(negedge clk);
    hs = src_val & src_ready;
    if (rst_n) begin
      chk("proto_err", proto_err, exp_err);
      for (int k = 0; k < N; k++) chk("pkt_cnt", pkt_cnt[k*CW +: CW], exp_cnt[k]);
      if (tx_val) begin
        if (cur_src < 0) begin
          chk("sop_at_pkt_start", tx_sop, 1'b1);
          pick = -1;
          for (int i = 1; i <= N; i++) begin
            int k;
            k = (model_last + i) % N;
            if (pick < 0 && expq[k].size() > 0 && src_en[k]) pick = k;
          end
          if (pick < 0) chk("spurious_val", tx_val, 1'b0);
          cur_src = pick;
          sop_order.push_back(tx_data[63:56]);
          if (gap_chk && eop_seen) chk("gap_cycles", 64'(cycle_no - last_eop_cyc), 64'(gap_len) + 64'd2);
        end
        if (cur_src >= 0) begin
          for (int k = 0; k < N; k++)
            chk("src_ready", src_ready[k], (k == cur_src) ? tx_ready : 1'b0);
          if (tx_ready) begin
            w = expq[cur_src].pop_front();
            chk("tx_data", tx_data, w.data);
            chk("tx_empty", tx_empty, w.empty);
            chk("tx_sop", tx_sop, w.sop);
            chk("tx_eop", tx_eop, w.eop);
            if (w.eop) begin
              exp_cnt[cur_src] = exp_cnt[cur_src] + 1'b1;
              model_last   = cur_src;
              cur_src      = -1;
              eop_seen     = 1'b1;
              last_eop_cyc = cycle_no;
            end
          end
        end
      end
      for (int k = 0; k < N; k++)
        if (hs[k] && srcq[k].size() > 0 && srcq[k][0].garbage) exp_err = 1'b1;
      if (cnt_clr) begin
        for (int k = 0; k < N; k++) exp_cnt[k] = '0;
        exp_err = 1'b0;
      end
    end
    cycle_no++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t g;
    logic [7:0] exp_order [6];
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_val", tx_val, 1'b0);
    chk("rst_tx_sop", tx_sop, 1'b0);
    chk("rst_tx_eop", tx_eop, 1'b0);
    chk("rst_tx_data", tx_data, 64'h0);
    chk("rst_tx_empty", tx_empty, 3'h0);
    chk("rst_src_ready", src_ready, 2'b00);
    chk("rst_pkt_cnt", pkt_cnt, 8'h00);
    chk("rst_proto_err", proto_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single 4-word packet, one-cycle arbitration latency
    push_pkt(0, 4, 1);
    @(negedge clk);
    chk("t1_arb_cycle_sop", tx_sop, 1'b0);
    @(negedge clk);
    chk("t1_first_sop", tx_sop, 1'b1);
    wait_idle(-1);
    chk("t1_cnt0", pkt_cnt[0 +: CW], 4'd1);
    chk("t1_err", proto_err, 1'b0);

    // Two continuous sources alternate per packet
    @(posedge clk); #1; rst_n = 1'b0; model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    gap_chk = 1'b1;
    sop_order.delete();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 2, 20 + p);
      push_pkt(1, 2, 30 + p);
    end
    wait_idle(-1);
    exp_order = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    chk("t2_nsop", 64'(sop_order.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk("t2_order", sop_order[i], exp_order[i]);
    chk("t2_cnt0", pkt_cnt[0 +: CW], 4'd3);
    chk("t2_cnt1", pkt_cnt[CW +: CW], 4'd3);

    // Gap of 3 between back-to-back packets
    gap_len  = 4'd3;
    eop_seen = 1'b0;
    for (int p = 0; p < 3; p++) push_pkt(0, 2, 40 + p);
    wait_idle(-1);
    gap_chk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    gap_len = 4'd0;

    // Downstream ready toggling mid-packet
    push_pkt(0, 4, 50);
    push_pkt(1, 2, 51);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    wait_idle(-1);
    chk("pre_clr_cnt0", pkt_cnt[0 +: CW], 4'd7);
    chk("pre_clr_cnt1", pkt_cnt[CW +: CW], 4'd4);

    // Garbage word while idle, then counter/flag clear
    g.data = 64'hDEAD_BEEF_0000_0001; g.empty = 3'd5;
    g.sop = 1'b0; g.eop = 1'b0; g.garbage = 1'b1;
    srcq[1].push_back(g);
    @(negedge clk);
    chk("t5_garbage_ready", src_ready[1], 1'b1);
    chk("t5_err_before", proto_err, 1'b0);
    @(negedge clk);
    chk("t5_err_set", proto_err, 1'b1);
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_err_clr", proto_err, 1'b0);
    chk("t5_cnt_clr", pkt_cnt, 8'h00);

    // Clear on the same edge as an eop increment
    @(posedge clk); #1;
    push_pkt(0, 1, 60);
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    wait_idle(-1);
    chk("t5_clr_wins", pkt_cnt[0 +: CW], 4'd0);

    // 16 packets wrap a 4-bit counter
    for (int p = 0; p < 16; p++) push_pkt(0, 1, 70 + p);
    wait_idle(-1);
    chk("t6_wrap_cnt0", pkt_cnt[0 +: CW], 4'd0);

    // Reset mid-packet truncates output
    push_pkt(0, 6, 90);
    for (int t = 0; t < 50 && expq[0].size() > 3; t++) @(negedge clk);
    chk("t7_midpkt", 64'(expq[0].size()), 64'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t7_rst_tx_val", tx_val, 1'b0);
    chk("t7_rst_tx_sop", tx_sop, 1'b0);
    chk("t7_rst_tx_eop", tx_eop, 1'b0);
    chk("t7_rst_tx_data", tx_data, 64'h0);
    chk("t7_rst_tx_empty", tx_empty, 3'h0);
    chk("t7_rst_ready", src_ready, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_pkt(0, 1, 95);
    @(negedge clk);
    chk("t7_idle_after_rst", tx_sop, 1'b0);
    @(negedge clk);
    chk("t7_sop_after_rst", tx_sop, 1'b1);
    wait_idle(-1);
    chk("t7_cnt0", pkt_cnt[0 +: CW], 4'd1);

    // Disabled source is never granted
    src_en[1] = 1'b0;
    push_pkt(1, 2, 100);
    push_pkt(0, 2, 101);
    wait_idle(1);
    repeat (3) @(negedge clk);
    chk("t8_dis_no_val", tx_val, 1'b0);
    chk("t8_dis_ready", src_ready[1], 1'b0);
    @(posedge clk); #1;
    src_en[1] = 1'b1;
    wait_idle(-1);
    chk("t8_cnt0", pkt_cnt[0 +: CW], 4'd2);
    chk("t8_cnt1", pkt_cnt[CW +: CW], 4'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_pkt_arb.md
Name: tx_pkt_arb

Overview:
- Transmit-side packet arbiter feeding the MAC TX stream (pkt_tx) of the traffic engine.
- Merges TX_DIR_CNT source streams into one stream with packet-granular round-robin: CPU network-stack TX, the traffic generator and the loopback path.
- Enforces a programmable minimum idle gap between packets.
- Keeps per-source packet counters and a sticky protocol-error flag.

Parameters:
- TX_DIR_CNT, 2, number of source streams (2..8); index 0 = CPU.
- DATA_W, 64, stream data width.
- EMPTY_W, 3, width of the empty-bytes field on the eop word.
- CNT_W, 32, width of each per-source packet counter.
- GAP_W, 4, width of the gap-length input.

Ports:
- clk_i  in  1  single clock for the block.
- rst_n_i  in  1  asynchronous active-low reset.
- src_data_i  in  TX_DIR_CNT*DATA_W  per-source data, source k at bits [k*DATA_W +: DATA_W].
- src_empty_i  in  TX_DIR_CNT*EMPTY_W  per-source empty byte count; meaningful on eop only.
- src_sop_i  in  TX_DIR_CNT  per-source start of packet.
- src_eop_i  in  TX_DIR_CNT  per-source end of packet.
- src_val_i  in  TX_DIR_CNT  per-source word valid.
- src_ready_o  out  TX_DIR_CNT  per-source ready.
- tx_data_o  out  DATA_W  merged data.
- tx_empty_o  out  EMPTY_W  merged empty.
- tx_sop_o, tx_eop_o, tx_val_o  out  1 each  merged framing and valid.
- tx_ready_i  in  1  downstream ready.
- gap_len_i  in  GAP_W  idle cycles forced after each eop (0 = back-to-back); quasi-static.
- src_en_i  in  TX_DIR_CNT  per-source enable; a disabled source is never granted.
- cnt_clr_i  in  1  synchronous clear of counters and error flag.
- pkt_cnt_o  out  TX_DIR_CNT*CNT_W  packets completed per source.
- proto_err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset: state = IDLE; grant = 0; last_grant = TX_DIR_CNT-1, so the first grant search starts at source 0; gap counter = 0; all counters = 0; proto_err_o = 0.
- Output reset values: src_ready_o = 0, tx_val_o = 0, tx_sop_o = 0, tx_eop_o = 0, tx_data_o = 0, tx_empty_o = 0.
- Handshake: a word transfers when val && ready on the same edge. Ready is never gated by val.
- State IDLE:
  - Request k = src_val_i[k] && src_sop_i[k] && src_en_i[k].
  - If any request is present, register grant = the first requester after last_grant, wrapping; then go to XFER.
  - Arbitration latency is one cycle: tx_sop_o is asserted at the earliest on the cycle after the request is first seen.
  - tx_val_o = 0 in IDLE.
  - A source presenting val without sop in IDLE is protocol garbage: src_ready_o[k] = 1 for it, the word is discarded and proto_err_o is set.
- State XFER:
  - tx_* = src_*[grant], combinational mux.
  - src_ready_o[grant] = tx_ready_i; all other readies = 0.
  - On transfer of the eop word: pkt_cnt[grant] += 1, last_grant = grant.
    - If gap_len_i = 0, go to IDLE.
    - Otherwise load the gap counter with gap_len_i and go to GAP.
  - A sop transferred mid-packet (after the first word) sets proto_err_o; the word is passed through unchanged.
  - sop and eop on the same word (single-word packet) is legal.
  - src_en_i deasserting mid-packet does not abort the packet.
- State GAP:
  - tx_val_o = 0, all readies = 0.
  - Decrement the counter each cycle; on reaching 1, go to IDLE.
  - Result: exactly gap_len_i idle cycles follow the eop transfer cycle, plus the one-cycle IDLE arbitration.
- Counters: wrap modulo 2^CNT_W with no saturation.
- cnt_clr_i:
  - Wins over a same-cycle increment: the counter reads 0 after that edge.
  - Also clears proto_err_o.
  - Does not affect the FSM.
- Reset asserted mid-packet: the packet is truncated on the output (no eop emitted) and the FSM returns to IDLE. Upstream is responsible for flushing.

Decomposition:
- Shared package tx_engine_pkg:
  - TX_DIR_CPU = 0, TX_DIR_GEN = 1, TX_DIR_LOOP = 2.
  - tx_arb_state_t enum {IDLE, XFER, GAP}.
  - Function rr_pick(req, last) returning a one-hot vector.
- Natural sub-module: tx_rr_sel, a combinational round-robin picker (req vector + last index -> granted index + any_req).
- The FSM, mux and counters stay in tx_pkt_arb.

Test Plan:
- Single source, 4-word packet from src 0, gap_len=0, tx_ready=1 -> sop at cycle 1 after request, 4 output words with data/empty intact, pkt_cnt[0]=1, proto_err=0.
- Both sources hold continuous 2-word packets, gap_len=0 -> output grant order 0,1,0,1; after 6 packets pkt_cnt[0]=3 and pkt_cnt[1]=3; no interleaving inside a packet.
- gap_len=3 with back-to-back requests -> exactly 3 GAP cycles plus 1 IDLE cycle between eop and the next sop.
- tx_ready toggled 1,0,1,0 mid-packet -> words advance only on ready cycles; the non-granted source sees ready=0 throughout.
- src 1 presents val without sop while IDLE -> word consumed, proto_err=1; cnt_clr pulse -> proto_err=0 and all counts 0.
- Counter preset near wrap (CNT_W=4 build), 16 packets -> count wraps to 0; rst_n_i pulsed mid-packet -> all outputs 0 and state IDLE on the next cycle.
